// File: rtl/otter_hazard_sequencer_if.sv
// Hazard/sequencing bundle between the OTTER datapath and its controller.
// slave = the sequencer, master = the pipeline side.
interface otter_hazard_sequencer_if #(
  parameter int STALL_CNT_W = 16
);
  logic [4:0] Rs1D, Rs2D;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [4:0] RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic       ResultSrcE0;
  logic       PCSrcE;
  logic       MulDivE;
  logic       MdDone;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE, FlushM;
  logic       MdStart, MdSelE;
  logic       MdBusy, MdError;
  logic [STALL_CNT_W-1:0] StallCount;

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE,
    input  RdM, RdW, RegWriteM, RegWriteW,
    input  ResultSrcE0, PCSrcE,
    input  MulDivE, MdDone,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE,
    output FlushD, FlushE, FlushM,
    output MdStart, MdSelE,
    output MdBusy, MdError, StallCount
  );

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE,
    output RdM, RdW, RegWriteM, RegWriteW,
    output ResultSrcE0, PCSrcE,
    output MulDivE, MdDone,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM,
    input  MdStart, MdSelE,
    input  MdBusy, MdError, StallCount
  );
endinterface

// File: rtl/otter_hazard_sequencer.sv
// OTTER hazard unit: forwarding, load-use/branch control and
// sequencing of the multi-cycle mul/div unit in Execute.
module otter_hazard_sequencer #(
  parameter int MD_TIMEOUT  = 64,
  parameter int STALL_CNT_W = 16
) (
  input logic CLK,
  input logic RESET,
  otter_hazard_sequencer_if.slave hz
);
  localparam int CW = $clog2(MD_TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(MD_TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} mdState_t;

  mdState_t state, stateNext;
  logic [CW-1:0] tmo, tmoNext;
  logic fsmStall, launch, selE, errSet;
  logic lwStall;

  function automatic logic [1:0] fwdSel(
    input logic [4:0] rs,
    input logic       wrM,
    input logic [4:0] rdM,
    input logic       wrW,
    input logic [4:0] rdW
  );
    logic [1:0] s;
    s = 2'b00;
    if (wrM && rdM != 5'd0 && rdM == rs)
      s = 2'b10;
    else if (wrW && rdW != 5'd0 && rdW == rs)
      s = 2'b01;
    return s;
  endfunction

  assign hz.ForwardAE = fwdSel(hz.Rs1E,
    hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign hz.ForwardBE = fwdSel(hz.Rs2E,
    hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

  assign lwStall = hz.ResultSrcE0 && hz.RdE != 5'd0 &&
    (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);

  always_comb begin
    stateNext = state;
    tmoNext   = tmo;
    launch    = 1'b0;
    fsmStall  = 1'b0;
    selE      = 1'b0;
    errSet    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hz.MulDivE) begin
          launch    = 1'b1;
          fsmStall  = 1'b1;
          stateNext = BUSY;
          tmoNext   = '0;
        end
      end
      BUSY: begin
        if (hz.MdDone) begin
          selE      = 1'b1;
          stateNext = IDLE;
        end else if (tmo == TMAX) begin
          errSet    = 1'b1;
          stateNext = IDLE;
        end else begin
          fsmStall  = 1'b1;
          tmoNext   = tmo + 1'b1;
        end
      end
    endcase
  end

  // FSM hold beats a branch, which beats a load-use stall
  assign hz.StallF = fsmStall | (~hz.PCSrcE & lwStall);
  assign hz.StallD = fsmStall | (~hz.PCSrcE & lwStall);
  assign hz.StallE = fsmStall;
  assign hz.FlushM = fsmStall;
  assign hz.FlushD = ~fsmStall & hz.PCSrcE;
  assign hz.FlushE = ~fsmStall & (hz.PCSrcE | lwStall);

  assign hz.MdStart = launch & RESET;
  assign hz.MdSelE  = selE & RESET;
  assign hz.MdBusy  = (state == BUSY);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      tmo   <= '0;
    end else begin
      state <= stateNext;
      tmo   <= tmoNext;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      hz.MdError <= 1'b0;
    else if (errSet)
      hz.MdError <= 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      hz.StallCount <= '0;
    else if (hz.StallF && hz.StallCount != '1)
      hz.StallCount <= hz.StallCount + 1'b1;
  end
endmodule

// File: tb/tb_otter_hazard_sequencer.sv
// Scoreboard bench for otter_hazard_sequencer.
// Expected controls are queued per driven cycle, popped at sample.
module tb_otter_hazard_sequencer;
  localparam logic [9:0] P_SF  = 10'b10_0000_0000;
  localparam logic [9:0] P_SD  = 10'b01_0000_0000;
  localparam logic [9:0] P_SE  = 10'b00_1000_0000;
  localparam logic [9:0] P_FD  = 10'b00_0100_0000;
  localparam logic [9:0] P_FE  = 10'b00_0010_0000;
  localparam logic [9:0] P_FM  = 10'b00_0001_0000;
  localparam logic [9:0] P_ST  = 10'b00_0000_1000;
  localparam logic [9:0] P_SEL = 10'b00_0000_0100;
  localparam logic [9:0] P_BSY = 10'b00_0000_0010;
  localparam logic [9:0] P_ERR = 10'b00_0000_0001;
  localparam logic [9:0] HOLD  = P_SF | P_SD | P_SE | P_FM;

  logic CLK;
  logic RESET;

  otter_hazard_sequencer_if #(.STALL_CNT_W(16)) hz();

  otter_hazard_sequencer #(
    .MD_TIMEOUT (4),
    .STALL_CNT_W(16)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .hz   (hz)
  );

  typedef struct {
    string      tag;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [9:0] ctl;
  } exp_t;

  exp_t sb[$];
  int checks;
  int failures;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ctlNow();
    return {hz.StallF, hz.StallD, hz.StallE,
            hz.FlushD, hz.FlushE, hz.FlushM,
            hz.MdStart, hz.MdSelE, hz.MdBusy, hz.MdError};
  endfunction

  task automatic clr();
    hz.Rs1D = 0; hz.Rs2D = 0;
    hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
    hz.RdM = 0; hz.RdW = 0;
    hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.ResultSrcE0 = 0; hz.PCSrcE = 0;
    hz.MulDivE = 0; hz.MdDone = 0;
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_fa"}, 32'(hz.ForwardAE), 32'(e.fa));
    chk({e.tag, "_fb"}, 32'(hz.ForwardBE), 32'(e.fb));
    chk({e.tag, "_ctl"}, 32'(ctlNow()), 32'(e.ctl));
  endtask

  // called at a negedge with inputs already driven
  task automatic cyc(string tag, logic [1:0] fa, logic [1:0] fb,
                     logic [9:0] ctl);
    sb.push_back('{tag, fa, fb, ctl});
    #2;
    sample();
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    RESET = 1'b0;
    clr();
    @(negedge CLK);
    cyc("rst", 2'b00, 2'b00, 10'd0);
    chk("rst_cnt", 32'(hz.StallCount), 0);
    RESET = 1'b1;
    @(negedge CLK);

    hz.RdM = 5; hz.RdW = 5; hz.Rs1E = 5;
    hz.RegWriteM = 1; hz.RegWriteW = 1;
    cyc("fwd_m", 2'b10, 2'b00, 10'd0);
    hz.RegWriteM = 0;
    cyc("fwd_w", 2'b01, 2'b00, 10'd0);
    hz.Rs1E = 0;
    cyc("fwd_r0", 2'b00, 2'b00, 10'd0);
    hz.Rs2E = 9; hz.RdW = 9; hz.RdM = 3; hz.RegWriteM = 1;
    cyc("fwdb_w", 2'b00, 2'b01, 10'd0);
    hz.RdM = 9;
    cyc("fwdb_m", 2'b00, 2'b10, 10'd0);
    hz.RdM = 0; hz.RdW = 0; hz.Rs1E = 0; hz.Rs2E = 0;
    cyc("fwd_rd0", 2'b00, 2'b00, 10'd0);
    clr();

    hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs2D = 7;
    cyc("lu_rs2", 2'b00, 2'b00, P_SF | P_SD | P_FE);
    hz.RdE = 0;
    cyc("lu_rd0", 2'b00, 2'b00, 10'd0);
    hz.RdE = 7; hz.Rs2D = 0; hz.Rs1D = 7;
    cyc("lu_rs1", 2'b00, 2'b00, P_SF | P_SD | P_FE);
    hz.PCSrcE = 1;
    cyc("br_lu", 2'b00, 2'b00, P_FD | P_FE);
    chk("cnt_lu", 32'(hz.StallCount), 2);
    clr();

    hz.MulDivE = 1;
    cyc("md_c0", 2'b00, 2'b00, HOLD | P_ST);
    cyc("md_c1", 2'b00, 2'b00, HOLD | P_BSY);
    hz.PCSrcE = 1; hz.ResultSrcE0 = 1; hz.RdE = 7; hz.Rs2D = 7;
    cyc("md_c2", 2'b00, 2'b00, HOLD | P_BSY);
    hz.PCSrcE = 0; hz.ResultSrcE0 = 0;
    cyc("md_c3", 2'b00, 2'b00, HOLD | P_BSY);
    hz.MdDone = 1;
    cyc("md_c4", 2'b00, 2'b00, P_SEL | P_BSY);
    chk("cnt_md", 32'(hz.StallCount), 6);
    clr();
    cyc("md_c5", 2'b00, 2'b00, 10'd0);
    hz.MdDone = 1;
    cyc("md_idle", 2'b00, 2'b00, 10'd0);
    hz.MdDone = 0;
    cyc("md_idle2", 2'b00, 2'b00, 10'd0);

    hz.MulDivE = 1;
    cyc("to_c0", 2'b00, 2'b00, HOLD | P_ST);
    cyc("to_c1", 2'b00, 2'b00, HOLD | P_BSY);
    cyc("to_c2", 2'b00, 2'b00, HOLD | P_BSY);
    cyc("to_c3", 2'b00, 2'b00, HOLD | P_BSY);
    cyc("to_c4", 2'b00, 2'b00, P_BSY);
    chk("cnt_to", 32'(hz.StallCount), 10);
    hz.MulDivE = 0;
    cyc("to_c5", 2'b00, 2'b00, P_ERR);
    hz.MdDone = 1;
    cyc("to_late", 2'b00, 2'b00, P_ERR);
    hz.MdDone = 0;
    cyc("to_stick", 2'b00, 2'b00, P_ERR);

    hz.MulDivE = 1;
    cyc("rb_c0", 2'b00, 2'b00, HOLD | P_ST | P_ERR);
    cyc("rb_c1", 2'b00, 2'b00, HOLD | P_BSY | P_ERR);
    RESET = 1'b0;
    hz.MulDivE = 0;
    #1;
    chk("rb_busy", 32'(hz.MdBusy), 0);
    chk("rb_cnt", 32'(hz.StallCount), 0);
    chk("rb_err", 32'(hz.MdError), 0);
    cyc("rb_c2", 2'b00, 2'b00, 10'd0);
    RESET = 1'b1;
    cyc("rb_idle", 2'b00, 2'b00, 10'd0);
    hz.MulDivE = 1;
    cyc("rb_l0", 2'b00, 2'b00, HOLD | P_ST);
    cyc("rb_l1", 2'b00, 2'b00, HOLD | P_BSY);
    hz.MdDone = 1;
    cyc("rb_l2", 2'b00, 2'b00, P_SEL | P_BSY);
    clr();
    cyc("rb_l3", 2'b00, 2'b00, 10'd0);
    chk("rb_cnt2", 32'(hz.StallCount), 2);
    chk("sb_drain", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/otter_hazard_sequencer.md
# otter_hazard_sequencer

Hazard and sequencing controller for the five-stage OTTER pipeline. It generates the execute-stage forwarding selects. It detects load-use hazards and taken-branch/jump flushes and drives the per-stage stall/flush controls. It also sequences an optional multi-cycle multiply/divide unit sitting beside the ALU in Execute, holding the front of the pipeline and bubbling Memory until the unit completes or times out.

## Interface
- MD_TIMEOUT, 64: maximum BUSY cycles allowed before a multi-cycle op is abandoned (≥2)
- STALL_CNT_W, 16: width of the saturating stall-cycle counter

- CLK  in  1  pipeline clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  source registers of the instruction in Decode
- Rs1E, Rs2E, RdE  in  5  source and destination registers in Execute
- RdM, RdW  in  5  destination registers in Memory and Writeback
- RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback
- ResultSrcE0  in  1  bit 0 of ResultSrcE; 1 means a load is in Execute
- PCSrcE  in  1  taken branch or jump resolved in Execute
- MulDivE  in  1  instruction in Execute is a multi-cycle op
- MdDone  in  1  multi-cycle unit result valid (single-cycle pulse)
- ForwardAE, ForwardBE  out  2  forwarding select: 00 = RD1E/RD2E, 01 = ResultW, 10 = ALUResultM
- StallF, StallD, StallE  out  1  hold the PC, the D register, and the E register
- FlushD, FlushE, FlushM  out  1  clear the D, E, and M pipeline registers (insert bubble)
- MdStart  out  1  one-cycle launch pulse to the multi-cycle unit
- MdSelE  out  1  select the multi-cycle result onto ALUResultE
- MdBusy  out  1  FSM in BUSY
- MdError  out  1  sticky timeout flag
- StallCount  out  STALL_CNT_W  saturating count of cycles with StallF=1

## Operation
- **Forwarding (combinational):**
  - ForwardAE = 10 if RegWriteM and RdM≠0 and RdM==Rs1E.
  - Otherwise ForwardAE = 01 if RegWriteW and RdW≠0 and RdW==Rs1E.
  - Otherwise ForwardAE = 00.
  - Memory has priority over Writeback. ForwardBE follows the same rules using Rs2E.
- **Load-use:** lwStall = ResultSrcE0 and RdE≠0 and (RdE==Rs1D or RdE==Rs2D).
- **FSM states IDLE, BUSY.**
  - IDLE with MulDivE=1: MdStart=1, StallF=StallD=StallE=1, FlushM=1; next state BUSY; timeout counter cleared.
  - BUSY with MdDone=0: StallF=StallD=StallE=1, FlushM=1, MdBusy=1; counter increments.
  - BUSY with MdDone=1: no stalls, MdSelE=1 (the result enters M at this edge); next state IDLE.
  - BUSY with counter==MD_TIMEOUT-1 and MdDone=0: no stalls, MdSelE=0, MdError set; next state IDLE.
  - MdDone in IDLE is ignored.
- **Priority, highest first:**
  1. FSM stall (IDLE-launch or BUSY): lwStall and PCSrcE are ignored and FlushD=FlushE=0.
  2. PCSrcE: FlushD=FlushE=1, StallF=StallD=0.
  3. lwStall: StallF=StallD=1, FlushE=1.
- StallE and FlushM are asserted only by the FSM.
- **Counters:**
  - The timeout counter is $clog2(MD_TIMEOUT) bits wide and never wraps within BUSY.
  - StallCount increments on each cycle with StallF=1 and saturates at all-ones.

## Timing
- Forwarding, stall, and flush outputs, plus MdStart and MdSelE, are combinational from inputs and state, valid in the same cycle.
- Launch latency: MulDivE seen at cycle t → MdStart during t → MdBusy=1 from t+1.
- The multi-cycle unit returns MdDone no earlier than t+1. If MdDone arrives at cycle k, the pipeline resumes at the edge ending k, and E holds the next instruction at k+1.
- A timeout launched at t releases during cycle t+MD_TIMEOUT.
- **RESET low (asynchronous, any time, including mid-BUSY):**
  - State returns to IDLE; the timeout counter, MdError, and StallCount go to 0.
  - MdBusy, MdStart, and MdSelE read 0.
  - Combinational outputs follow inputs from an IDLE state.
- MdError clears only on reset.

## Test plan
- **Forwarding priority:** RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10. With RegWriteM=0 → ForwardAE=01. With Rs1E=0 → ForwardAE=00.
- **Load-use:** ResultSrcE0=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle. Same inputs with RdE=0 → no stall.
- **Branch versus load-use:** PCSrcE=1 and lwStall true in the same cycle → FlushD=FlushE=1, StallF=StallD=0.
- **Multi-cycle op:** MulDivE=1 at cycle 0, MdDone at cycle 4 → MdStart only at cycle 0; StallF/D/E and FlushM high for cycles 0–3; MdSelE=1 and stalls low at cycle 4; MdBusy low at cycle 5; StallCount=4.
- **Timeout:** MD_TIMEOUT=4, MulDivE=1 at cycle 0, no MdDone → stalls released at cycle 4, MdError=1 from cycle 5 and sticky. A later MdDone is ignored.
- **Reset mid-BUSY:** drop RESET at cycle 2 of an op → MdBusy=0 and StallCount=0 immediately; after release, the FSM is IDLE and responds to a new MulDivE.
